// File: rtl/usb_frame_tx.sv
// ---------------------------------------------------------------------------
// usb_frame_tx
//
// Sends one radar frame from the ADC sample FIFO to the FT2232H
// synchronous-FIFO write port. A frame is START_FLAG, then FRAME_LEN payload
// bytes, then STOP_FLAG. The capture side asks for a frame with a four-phase
// req/done handshake. If the sample FIFO stays starved for TIMEOUT
// consecutive cycles, the frame is cut short and closed with STOP_FLAG.
// The whole block runs in the 60 MHz FT2232H clock domain.
//
// Ports
//   clk           FT2232H clkout
//   rst_n         asynchronous active-low reset
//   frame_req_i   capture side has a full frame buffered (level)
//   frame_done_o  frame sent; held high until frame_req_i falls
//   busy_o        a frame is being sequenced
//   err_o         the last frame was aborted by the starvation timeout
//   byte_cnt_o    payload bytes accepted by the FT2232H in this frame
//   fifo_empty_i  sample FIFO empty
//   fifo_ren_o    sample FIFO read enable (data valid on the next cycle)
//   fifo_rdata_i  sample FIFO read data
//   ft_txe_n_i    low while the FT2232H can accept a byte
//   ft_wr_n_o     registered write strobe, low while a byte is presented
//   ft_data_o     registered write data
// ---------------------------------------------------------------------------
module usb_frame_tx #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FRAME_LEN  = 40960,
  parameter logic [DATA_WIDTH-1:0] START_FLAG = 8'h5A,
  parameter logic [DATA_WIDTH-1:0] STOP_FLAG  = 8'hA5,
  parameter int                    TIMEOUT    = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_req_i,
  output logic                           frame_done_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [$clog2(FRAME_LEN+1)-1:0] byte_cnt_o,
  input  logic                           fifo_empty_i,
  output logic                           fifo_ren_o,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata_i,
  input  logic                           ft_txe_n_i,
  output logic                           ft_wr_n_o,
  output logic [DATA_WIDTH-1:0]          ft_data_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] LEN_C     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C    = CW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] TO_LAST_C = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  state_e                state_q;
  logic                  ftWrN_q;
  logic [DATA_WIDTH-1:0] ftData_q;
  logic                  skidValid_q;
  logic [DATA_WIDTH-1:0] skidData_q;
  logic                  rdPend_q;
  logic [CW-1:0]         reqCnt_q;
  logic [CW-1:0]         byteCnt_q;
  logic [SW-1:0]         starve_q;
  logic                  err_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  accept;
  logic                  outFree;
  logic                  starved;
  logic                  abort;
  logic [1:0]            occ;
  logic                  ren;

  // Handshake and buffer bookkeeping. occ counts output register, skid
  // register and the read in flight, minus a byte leaving on this edge. The
  // read is issued only if the returning byte is guaranteed a slot. While
  // the START flag is accepted, the first read goes out on the same cycle.
  always_comb begin
    accept  = ~ftWrN_q & ~ft_txe_n_i;
    outFree = ftWrN_q | accept;
    starved = (state_q == DATA) && fifo_empty_i && ftWrN_q &&
              !skidValid_q && !rdPend_q;
    abort   = (TIMEOUT > 0) && starved && (starve_q == TO_LAST_C);
    occ     = {1'b0, ~ftWrN_q} + {1'b0, skidValid_q} + {1'b0, rdPend_q} -
              {1'b0, accept};
    ren     = ((state_q == DATA) || ((state_q == START) && accept)) &&
              !abort && !fifo_empty_i && (reqCnt_q < LEN_C) && (occ < 2'd2);
  end

  // Frame sequencer and payload datapath. The output register reloads on
  // the edge where its byte is accepted. The skid register is always older
  // than a byte arriving from the FIFO, so it drains into the output first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ftWrN_q     <= 1'b1;
      ftData_q    <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      rdPend_q    <= 1'b0;
      reqCnt_q    <= '0;
      byteCnt_q   <= '0;
      starve_q    <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_req_i && !done_q) begin
            state_q     <= START;
            ftWrN_q     <= 1'b0;
            ftData_q    <= START_FLAG;
            skidValid_q <= 1'b0;
            rdPend_q    <= 1'b0;
            reqCnt_q    <= '0;
            byteCnt_q   <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        START: begin
          rdPend_q <= ren;
          if (ren) reqCnt_q <= reqCnt_q + CW'(1);
          if (accept) begin
            state_q <= DATA;
            ftWrN_q <= 1'b1;
          end
        end

        DATA: begin
          rdPend_q <= ren;
          if (ren) reqCnt_q <= reqCnt_q + CW'(1);
          if (accept) byteCnt_q <= byteCnt_q + CW'(1);

          if (ren || !starved) starve_q <= '0;
          else if (TIMEOUT > 0) starve_q <= starve_q + SW'(1);

          // The buffers are empty at both exits to STOP, so STOP_FLAG can
          // go straight into the output register.
          if (abort) begin
            err_q    <= 1'b1;
            state_q  <= STOP;
            ftWrN_q  <= 1'b0;
            ftData_q <= STOP_FLAG;
          end else if (accept && (byteCnt_q == LAST_C)) begin
            state_q  <= STOP;
            ftWrN_q  <= 1'b0;
            ftData_q <= STOP_FLAG;
          end else if (outFree) begin
            if (skidValid_q) begin
              ftWrN_q     <= 1'b0;
              ftData_q    <= skidData_q;
              skidValid_q <= rdPend_q;
              if (rdPend_q) skidData_q <= fifo_rdata_i;
            end else if (rdPend_q) begin
              ftWrN_q  <= 1'b0;
              ftData_q <= fifo_rdata_i;
            end else begin
              ftWrN_q <= 1'b1;
            end
          end else if (rdPend_q) begin
            skidValid_q <= 1'b1;
            skidData_q  <= fifo_rdata_i;
          end
        end

        STOP: begin
          if (accept) begin
            state_q <= DONE;
            ftWrN_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        DONE: begin
          if (!frame_req_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          ftWrN_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_ren_o   = ren;
  assign ft_wr_n_o    = ftWrN_q;
  assign ft_data_o    = ftData_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign byte_cnt_o   = byteCnt_q;

endmodule

// File: tb/tb_usb_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_frame_tx
//
// Bench for usb_frame_tx with FRAME_LEN=8 and TIMEOUT=16. A small FIFO
// model feeds the DUT. The stimulus pushes every byte it expects on the USB
// pins into a queue. A monitor pops that queue on each accepted byte.
// ---------------------------------------------------------------------------
module tb_usb_frame_tx;

  localparam int FL = 8;
  localparam int TO = 16;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_req_i;
  logic          frame_done_o;
  logic          busy_o;
  logic          err_o;
  logic [CW-1:0] byte_cnt_o;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_ren_o;
  logic [7:0]    fifo_rdata_i = 8'h00;
  logic          ft_txe_n_i;
  logic          ft_wr_n_o;
  logic [7:0]    ft_data_o;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];
  logic [7:0] fifoQ[$];
  logic       renS = 1'b0;
  int         cycleCnt = 0;
  int         accCount = 0;
  int         lastPayCycle = 0;
  int         stopCycle = 0;
  int         reads = 0;
  int         payAcc = 0;
  int         maxOcc = 0;

  always #5 clk = ~clk;

  usb_frame_tx #(
    .DATA_WIDTH(8),
    .FRAME_LEN (FL),
    .START_FLAG(8'h5A),
    .STOP_FLAG (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_req_i (frame_req_i),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .byte_cnt_o  (byte_cnt_o),
    .fifo_empty_i(fifo_empty_i),
    .fifo_ren_o  (fifo_ren_o),
    .fifo_rdata_i(fifo_rdata_i),
    .ft_txe_n_i  (ft_txe_n_i),
    .ft_wr_n_o   (ft_wr_n_o),
    .ft_data_o   (ft_data_o)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Sample FIFO model: a read requested during a cycle returns its byte
  // just after the following edge.
  always @(posedge clk) begin
    cycleCnt++;
    #1;
    if (renS) begin
      if (fifoQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fifoUnderflow: read issued at cycle %0d, required no read while empty", cycleCnt);
      end else begin
        fifo_rdata_i = fifoQ.pop_front();
      end
    end
    fifo_empty_i = (fifoQ.size() == 0);
  end

  // Monitor: sees each byte the FT2232H takes on the next edge and checks it
  // against the scoreboard. It also tracks how many payload bytes are
  // buffered in the DUT or in flight.
  always @(negedge clk) begin
    renS = fifo_ren_o;
    if (rst_n) begin
      if (fifo_ren_o) reads++;
      if (!ft_wr_n_o && !ft_txe_n_i) begin
        accCount++;
        if (ft_data_o != 8'h5A && ft_data_o != 8'hA5) begin
          payAcc++;
          lastPayCycle = cycleCnt;
        end
        if (ft_data_o == 8'hA5) stopCycle = cycleCnt;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedByte: got 0x%0h, required no byte", ft_data_o);
        end else begin
          checkOutput("streamByte", int'(ft_data_o), int'(expQ.pop_front()));
        end
      end
      if (reads - payAcc > maxOcc) maxOcc = reads - payAcc;
    end
  end

  task automatic syncStim();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic req, input logic txeN);
    syncStim();
    frame_req_i = req;
    ft_txe_n_i  = txeN;
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifoQ.push_back(8'(first + i));
  endtask

  task automatic expectFrame(input logic [7:0] first, input int n);
    expQ.push_back(8'h5A);
    for (int i = 0; i < n; i++) expQ.push_back(8'(first + i));
    expQ.push_back(8'hA5);
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!frame_done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_done_o) begin
      errors++;
      $display("[TB] FAIL %s: frame_done_o=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (!busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(busy_o), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hsW;
    int gapW;
    int startAcc;
    bit found;

    rst_n       = 1'b0;
    frame_req_i = 1'b0;
    ft_txe_n_i  = 1'b0;

    // Reset values
    #12;
    checkOutput("rstWrN",  int'(ft_wr_n_o),    1);
    checkOutput("rstData", int'(ft_data_o),    0);
    checkOutput("rstRen",  int'(fifo_ren_o),   0);
    checkOutput("rstDone", int'(frame_done_o), 0);
    checkOutput("rstBusy", int'(busy_o),       0);
    checkOutput("rstErr",  int'(err_o),        0);
    checkOutput("rstCnt",  int'(byte_cnt_o),   0);
    syncStim();
    rst_n = 1'b1;

    // Nominal frame, req only pulsed: the frame must still complete
    $display("[TB] nominal frame");
    syncStim();
    preload(8'h01, 8);
    expectFrame(8'h01, 8);
    frame_req_i = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone("nominalDone", 100);
    checkOutput("nominalCnt", int'(byte_cnt_o), 8);
    checkOutput("nominalErr", int'(err_o), 0);
    checkOutput("nominalDrained", expQ.size(), 0);
    repeat (3) @(posedge clk);

    // TX backpressure: hold 0x13 for 5 cycles
    $display("[TB] tx backpressure");
    syncStim();
    preload(8'h11, 8);
    expectFrame(8'h11, 8);
    frame_req_i = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      syncStim();
      if (!ft_wr_n_o && ft_data_o == 8'h13) found = 1;
    end
    checkOutput("stallReached", int'(found), 1);
    if (found) begin
      ft_txe_n_i = 1'b1;
      repeat (5) begin
        @(negedge clk);
        checkOutput("stallHold", int'({ft_wr_n_o, ft_data_o}), int'({1'b0, 8'h13}));
      end
      applyStimulus(1'b1, 1'b0);
    end
    waitDone("stallDone", 100);
    checkOutput("stallCnt", int'(byte_cnt_o), 8);
    checkOutput("stallDrained", expQ.size(), 0);
    checks++;
    if (maxOcc > 2) begin
      errors++;
      $display("[TB] FAIL maxBuffered: got %0d, required at most 2", maxOcc);
    end
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // FIFO gap: 4 bytes, 10 empty cycles, then the remaining 4
    $display("[TB] fifo gap");
    syncStim();
    preload(8'h21, 4);
    expectFrame(8'h21, 8);
    frame_req_i = 1'b1;
    startAcc = accCount;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      syncStim();
      if (accCount >= startAcc + 5) found = 1;
    end
    checkOutput("gapReached", int'(found), 1);
    gapW = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ft_wr_n_o) gapW++;
    end
    checkOutput("gapNoStrobe", gapW, 0);
    syncStim();
    preload(8'h25, 4);
    waitDone("gapDone", 100);
    checkOutput("gapCnt", int'(byte_cnt_o), 8);
    checkOutput("gapErr", int'(err_o), 0);
    checkOutput("gapDrained", expQ.size(), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Timeout: 3 bytes only, then 16 starved cycles
    $display("[TB] starvation timeout");
    syncStim();
    preload(8'h31, 3);
    expectFrame(8'h31, 3);
    frame_req_i = 1'b1;
    waitDone("toDone", 200);
    checkOutput("toErr", int'(err_o), 1);
    checkOutput("toCnt", int'(byte_cnt_o), 3);
    checkOutput("toDoneHigh", int'(frame_done_o), 1);
    checkOutput("toStopDelay", stopCycle - lastPayCycle, 17);
    checkOutput("toDrained", expQ.size(), 0);

    // Handshake: req held high after done must not start another frame
    $display("[TB] four-phase handshake");
    hsW = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ft_wr_n_o) hsW++;
    end
    checkOutput("hsNoRestart", hsW, 0);
    checkOutput("hsDoneHeld", int'(frame_done_o), 1);
    checkOutput("hsBusyLow", int'(busy_o), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("hsDoneClear", int'(frame_done_o), 0);
    syncStim();
    preload(8'h41, 8);
    expectFrame(8'h41, 8);
    frame_req_i = 1'b1;
    waitBusy("hsRestart");
    checkOutput("hsErrCleared", int'(err_o), 0);
    waitDone("hsDone", 100);
    checkOutput("hsCnt", int'(byte_cnt_o), 8);
    checkOutput("hsErr", int'(err_o), 0);
    checkOutput("hsDrained", expQ.size(), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Reset after 4 payload bytes
    $display("[TB] reset mid frame");
    syncStim();
    preload(8'h61, 8);
    expQ.push_back(8'h5A);
    for (int i = 0; i < 4; i++) expQ.push_back(8'(8'h61 + i));
    frame_req_i = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      syncStim();
      if (byte_cnt_o == 4) found = 1;
    end
    checkOutput("rstMidReached", int'(found), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidWrN",  int'(ft_wr_n_o),  1);
    checkOutput("rstMidRen",  int'(fifo_ren_o), 0);
    checkOutput("rstMidBusy", int'(busy_o),     0);
    checkOutput("rstMidCnt",  int'(byte_cnt_o), 0);
    checkOutput("rstMidData", int'(ft_data_o),  0);
    checkOutput("rstMidDrained", expQ.size(), 0);
    fifoQ.delete();
    repeat (2) @(posedge clk);
    syncStim();
    rst_n = 1'b1;
    preload(8'h71, 8);
    expectFrame(8'h71, 8);
    waitBusy("rstRestart");
    checkOutput("rstRestartCnt", int'(byte_cnt_o), 0);
    waitDone("rstRestartDone", 100);
    checkOutput("rstRestartFinalCnt", int'(byte_cnt_o), 8);
    checkOutput("rstRestartErr", int'(err_o), 0);
    checkOutput("rstRestartDrained", expQ.size(), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
